wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/mips_pkg.sv | 16 +
 rtl/regfile_array.sv | 52 +++++
 rtl/wb_regfile.sv | 99 +++++++++
 tb/tb_wb_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS writeback / register-file slice.
package mips_pkg;

    localparam int NREGS = 32;
    localparam int DW    = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_MEM  = 2'd1,
        WB_SRC_LINK = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_array.sv
// Register storage: one write port, two non-bypassed read ports, plus an
// optional debug read port when WB_DEBUG_PORT_EN is defined.
module regfile_array
    import mips_pkg::*;
#(
    parameter int NREGS = mips_pkg::NREGS,
    parameter int DW    = mips_pkg::DW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [4:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [4:0]    i_raddr_a,
    input  logic [4:0]    i_raddr_b,
`ifdef WB_DEBUG_PORT_EN
    input  logic [4:0]    i_raddr_dbg,
    output logic [DW-1:0] o_rdata_dbg,
`endif
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] mem_q [NREGS];
    logic [DW-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (i_we && i_waddr != REG_ZERO) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // r0 is forced to zero on read so its storage never matters
    assign o_rdata_a = (i_raddr_a == REG_ZERO) ? '0 : mem_q[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == REG_ZERO) ? '0 : mem_q[i_raddr_b];

`ifdef WB_DEBUG_PORT_EN
    assign o_rdata_dbg = (i_raddr_dbg == REG_ZERO) ? '0 : mem_q[i_raddr_dbg];
`endif

endmodule

// File: rtl/wb_regfile.sv
// MIPS writeback stage + register file: writeback mux, write-first bypass,
// sticky halt and cycle counter. Define WB_DEBUG_PORT_EN for a debug read port.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int NREGS = mips_pkg::NREGS,
    parameter int DW    = mips_pkg::DW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clk_en,
    input  logic [DW-1:0] i_wb_data,
    input  logic [DW-1:0] i_wb_alu_result,
    input  logic [DW-1:0] i_wb_pc_plus_8,
    input  logic [4:0]    i_wb_rd,
    input  logic          i_wb_mem_to_reg,
    input  logic          i_wb_reg_write,
    input  logic          i_wb_isJal,
    input  logic          i_wb_halt,
    input  logic [4:0]    i_rs_addr,
    input  logic [4:0]    i_rt_addr,
`ifdef WB_DEBUG_PORT_EN
    input  logic [4:0]    i_dbg_addr,
    output logic [DW-1:0] o_dbg_data,
`endif
    output logic [DW-1:0] o_rs_data,
    output logic [DW-1:0] o_rt_data,
    output logic [DW-1:0] o_wb_write_data,
    output logic          o_halted,
    output logic [31:0]   o_cycle_count
);

    wb_src_e       wb_src;
    logic          wr_en;
    logic [DW-1:0] arr_rs_data;
    logic [DW-1:0] arr_rt_data;
    logic          halted_q, halted_d;
    logic [31:0]   cycle_q, cycle_d;

    always_comb begin
        wb_src = WB_SRC_ALU;
        if (i_wb_isJal)           wb_src = WB_SRC_LINK;
        else if (i_wb_mem_to_reg) wb_src = WB_SRC_MEM;

        case (wb_src)
            WB_SRC_LINK: o_wb_write_data = i_wb_pc_plus_8;
            WB_SRC_MEM:  o_wb_write_data = i_wb_data;
            default:     o_wb_write_data = i_wb_alu_result;
        endcase
    end

    // A write in the halt cycle itself still lands; halted_q only blocks later ones
    assign wr_en = i_clk_en && i_wb_reg_write && (i_wb_rd != REG_ZERO) && !halted_q;

    regfile_array #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_array (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_we        (wr_en),
        .i_waddr     (i_wb_rd),
        .i_wdata     (o_wb_write_data),
        .i_raddr_a   (i_rs_addr),
        .i_raddr_b   (i_rt_addr),
`ifdef WB_DEBUG_PORT_EN
        .i_raddr_dbg (i_dbg_addr),
        .o_rdata_dbg (o_dbg_data),
`endif
        .o_rdata_a   (arr_rs_data),
        .o_rdata_b   (arr_rt_data)
    );

    assign o_rs_data = (wr_en && i_rs_addr == i_wb_rd) ? o_wb_write_data : arr_rs_data;
    assign o_rt_data = (wr_en && i_rt_addr == i_wb_rd) ? o_wb_write_data : arr_rt_data;

    always_comb begin
        halted_d = halted_q;
        cycle_d  = cycle_q;
        if (i_clk_en) begin
            if (i_wb_halt) halted_d = 1'b1;
            if (!halted_q) cycle_d  = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            halted_q <= 1'b0;
            cycle_q  <= '0;
        end else begin
            halted_q <= halted_d;
            cycle_q  <= cycle_d;
        end
    end

    assign o_halted      = halted_q;
    assign o_cycle_count = cycle_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an architectural reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset, clk_en;
    logic [31:0] wb_data, alu, pc8;
    logic [4:0]  rd, rs_addr, rt_addr;
    logic        mem_to_reg, reg_write, is_jal, halt;
    logic [31:0] rs_data, rt_data, wd;
    logic        halted;
    logic [31:0] cycle_count;
`ifdef WB_DEBUG_PORT_EN
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [31:0] m_regs [32];
    logic        m_halted;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    wb_regfile dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_clk_en        (clk_en),
        .i_wb_data       (wb_data),
        .i_wb_alu_result (alu),
        .i_wb_pc_plus_8  (pc8),
        .i_wb_rd         (rd),
        .i_wb_mem_to_reg (mem_to_reg),
        .i_wb_reg_write  (reg_write),
        .i_wb_isJal      (is_jal),
        .i_wb_halt       (halt),
        .i_rs_addr       (rs_addr),
        .i_rt_addr       (rt_addr),
`ifdef WB_DEBUG_PORT_EN
        .i_dbg_addr      (dbg_addr),
        .o_dbg_data      (dbg_data),
`endif
        .o_rs_data       (rs_data),
        .o_rt_data       (rt_data),
        .o_wb_write_data (wd),
        .o_halted        (halted),
        .o_cycle_count   (cycle_count)
    );

    function automatic logic [31:0] m_wdata();
        if (is_jal)          return pc8;
        else if (mem_to_reg) return wb_data;
        else                 return alu;
    endfunction

    function automatic logic m_writes();
        return clk_en && reg_write && rd != 5'd0 && !m_halted;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (m_writes() && a == rd) return m_wdata();
        return m_regs[a];
    endfunction

    task automatic idle();
        reset = 0; clk_en = 0; wb_data = 0; alu = 0; pc8 = 0; rd = 0;
        mem_to_reg = 0; reg_write = 0; is_jal = 0; halt = 0; rs_addr = 0; rt_addr = 0;
    endtask

    // Update the model from the inputs applied this cycle, then clock the DUT.
    task automatic tick();
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_halted = 0;
            m_count  = 0;
        end else if (clk_en) begin
            if (m_writes()) m_regs[rd] = m_wdata();
            if (!m_halted) m_count = m_count + 1;
            if (halt) m_halted = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %0b want 0", halted); else n_pass++;
        n_checks++; if (cycle_count !== 32'd0) $display("FAIL reset_count got %0d want 0", cycle_count); else n_pass++;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(31 - a); #1;
            n_checks++;
            if (rs_data !== 32'd0 || rt_data !== 32'd0)
                $display("FAIL reset_reg r%0d rs=%h rt=%h want 0", a, rs_data, rt_data);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        idle(); clk_en = 1; reg_write = 1; rd = 5; alu = 32'h1234;
        tick();
        idle(); rs_addr = 5; #1;
        n_checks++; if (rs_data !== 32'h1234) $display("FAIL write_read got %h want 00001234", rs_data); else n_pass++;
    endtask

    task automatic test_bypass();
        idle(); clk_en = 1; reg_write = 1; rd = 7; mem_to_reg = 1;
        wb_data = 32'hDEADBEEF; alu = 32'h1111; rs_addr = 7; rt_addr = 7; #1;
        n_checks++; if (rs_data !== 32'hDEADBEEF) $display("FAIL bypass_rs got %h want deadbeef", rs_data); else n_pass++;
        n_checks++; if (rt_data !== 32'hDEADBEEF) $display("FAIL bypass_rt got %h want deadbeef", rt_data); else n_pass++;
        n_checks++; if (wd !== 32'hDEADBEEF) $display("FAIL wb_write_data got %h want deadbeef", wd); else n_pass++;
        tick();
        idle(); rs_addr = 7; #1;
        n_checks++; if (rs_data !== 32'hDEADBEEF) $display("FAIL bypass_stored got %h want deadbeef", rs_data); else n_pass++;
    endtask

    task automatic test_link_r0();
        idle(); clk_en = 1; reg_write = 1; is_jal = 1; mem_to_reg = 1; rd = 31;
        pc8 = 32'h40; alu = 32'h99; wb_data = 32'h77;
        tick();
        idle(); clk_en = 1; reg_write = 1; rd = 0; alu = 32'h55; rs_addr = 0; #1;
        n_checks++; if (rs_data !== 32'd0) $display("FAIL r0_no_bypass got %h want 0", rs_data); else n_pass++;
        tick();
        idle(); rs_addr = 31; rt_addr = 0; #1;
        n_checks++; if (rs_data !== 32'h40) $display("FAIL link_r31 got %h want 00000040", rs_data); else n_pass++;
        n_checks++; if (rt_data !== 32'd0) $display("FAIL r0_discard got %h want 0", rt_data); else n_pass++;
    endtask

    task automatic test_clk_en();
        logic [31:0] count0;
        idle(); clk_en = 1; reg_write = 1; rd = 9; alu = 32'hA5A5;
        tick();
        count0 = cycle_count;
        for (int i = 0; i < 4; i++) begin
            idle(); reg_write = 1; halt = (i == 2); rd = 9; alu = 32'h1000 + 32'(i); rs_addr = 9; #1;
            n_checks++; if (rs_data !== 32'hA5A5) $display("FAIL clk_en_bypass got %h want 0000a5a5", rs_data); else n_pass++;
            tick();
        end
        idle(); rs_addr = 9; #1;
        n_checks++; if (rs_data !== 32'hA5A5) $display("FAIL clk_en_hold_reg got %h want 0000a5a5", rs_data); else n_pass++;
        n_checks++; if (cycle_count !== count0) $display("FAIL clk_en_hold_count got %0d want %0d", cycle_count, count0); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL clk_en_hold_halt got %0b want 0", halted); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle(); clk_en = 1;
            tick();
        end
        idle(); clk_en = 1; halt = 1; reg_write = 1; rd = 3; alu = 32'h7;
        tick();
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_flag got %0b want 1", halted); else n_pass++;
        n_checks++; if (cycle_count !== 32'd11) $display("FAIL halt_count got %0d want 11", cycle_count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            idle(); clk_en = 1; reg_write = 1; rd = 3; alu = 32'hAA; rs_addr = 3; #1;
            n_checks++; if (rs_data !== 32'h7) $display("FAIL halted_no_bypass got %h want 00000007", rs_data); else n_pass++;
            tick();
        end
        idle(); rs_addr = 3; #1;
        n_checks++; if (rs_data !== 32'h7) $display("FAIL halted_r3 got %h want 00000007", rs_data); else n_pass++;
        n_checks++; if (cycle_count !== 32'd11) $display("FAIL halted_count got %0d want 11", cycle_count); else n_pass++;
        n_checks++; if (halted !== 1'b1) $display("FAIL halt_sticky got %0b want 1", halted); else n_pass++;
        // reset while halted, with a write and halt also pending
        idle(); reset = 1; clk_en = 1; reg_write = 1; rd = 4; alu = 32'hBAD; halt = 1;
        tick();
        idle();
        n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted_flag got %0b want 0", halted); else n_pass++;
        n_checks++; if (cycle_count !== 32'd0) $display("FAIL reset_halted_count got %0d want 0", cycle_count); else n_pass++;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); #1;
            n_checks++; if (rs_data !== 32'd0) $display("FAIL reset_halted_reg r%0d got %h want 0", a, rs_data); else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            clk_en     = ($urandom_range(0, 3) != 0);
            reg_write  = ($urandom_range(0, 3) != 0);
            mem_to_reg = $urandom_range(0, 1);
            is_jal     = ($urandom_range(0, 5) == 0);
            halt       = (i > 350) && ($urandom_range(0, 9) == 0);
            rd         = 5'($urandom_range(0, 31));
            wb_data    = $urandom; alu = $urandom; pc8 = $urandom;
            rs_addr    = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rt_addr    = 5'($urandom_range(0, 31));
            #1;
            n_checks++; if (wd !== m_wdata()) $display("FAIL rand_wd[%0d] got %h want %h", i, wd, m_wdata()); else n_pass++;
            if (!reset) begin
                n_checks++; if (rs_data !== m_read(rs_addr)) $display("FAIL rand_rs[%0d] r%0d got %h want %h", i, rs_addr, rs_data, m_read(rs_addr)); else n_pass++;
                n_checks++; if (rt_data !== m_read(rt_addr)) $display("FAIL rand_rt[%0d] r%0d got %h want %h", i, rt_addr, rt_data, m_read(rt_addr)); else n_pass++;
            end
            tick();
            n_checks++; if (cycle_count !== m_count) $display("FAIL rand_count[%0d] got %0d want %0d", i, cycle_count, m_count); else n_pass++;
            n_checks++; if (halted !== m_halted) $display("FAIL rand_halted[%0d] got %0b want %0b", i, halted, m_halted); else n_pass++;
`ifdef WB_DEBUG_PORT_EN
            dbg_addr = rt_addr; #1;
            n_checks++; if (dbg_data !== m_regs[dbg_addr]) $display("FAIL rand_dbg[%0d] got %h want %h", i, dbg_data, m_regs[dbg_addr]); else n_pass++;
`endif
        end
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 0;
        m_halted = 0;
        m_count  = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_link_r0();
        test_clk_en();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
